vlsu_txn_splitter: RTL
======================

// Module: vlsu_txn_splitter
// PURPOSE
//  Parametrised successor of the VLSU request fragmenter. Takes one VLSU request (unit-stride or strided)
//  and emits a stream of memory transaction descriptors. Every descriptor is bounded by a configurable
//  MaxTxnNbs-aligned window, so it never crosses a burst or page limit. Sits between the VLSU request
//  queue and the AXI address generator; one request is in flight at a time, with a done pulse per request.
// PARAMETERS
//  AddrW      64    byte-address width; the internal nibble address is AddrW+1 bits
//  ElemW      16    width of the element count
//  IdW        4     request id width
//  MaxTxnNbs  8192  max nibbles per transaction; power of 2, >=8 (8192 = 4 KiB page)
// PORTS
//  clk_i         in   1          clock
//  rst_ni        in   1          asynchronous, active-low reset
//  req_valid_i   in   1          request valid
//  req_ready_o   out  1          request ready; 1 only in S_IDLE
//  req_addr_i    in   AddrW      base byte address
//  req_stride_i  in   AddrW      byte stride, two's complement (strided mode only)
//  req_nr_elem_i in   ElemW      element count
//  req_sew_i     in   2          element = 1<<sew nibbles
//  req_strd_i    in   1          1 = strided, 0 = unit-stride
//  req_id_i      in   IdW        request id, echoed on every txn
//  stall_i       in   1          downstream resource busy (pending store / meta buffer full)
//  txn_valid_o   out  1          descriptor valid
//  txn_ready_i   in   1          descriptor accepted
//  txn_addr_o    out  AddrW+1    nibble start address
//  txn_nbs_o     out  $clog2(MaxTxnNbs)+1  nibble count, 1..MaxTxnNbs
//  txn_first_o   out  1          first txn of the request
//  txn_last_o    out  1          last txn of the request
//  txn_id_o      out  IdW        request id
//  done_o        out  1          one-cycle pulse: request fully issued
// BEHAVIOUR
//  - Reset: state S_IDLE; all registers 0; txn_valid_o=0, done_o=0, req_ready_o=1. A mid-operation reset drops the request.
//  - FSM:
//    - S_IDLE: accept on valid&ready. nr_elem==0 -> pulse done_o next cycle, stay in S_IDLE. Otherwise -> S_SEG_INIT.
//    - S_SEG_INIT: load seg_addr and seg_rmn; stall_i ? S_STALL : S_ISSUE.
//    - S_STALL: remain while stall_i=1, else -> S_ISSUE.
//    - S_ISSUE: txn_valid_o=1.
//  - Issue rules:
//    - Descriptor fields are stable while valid&!ready; valid never drops without a handshake.
//    - stall_i is ignored in S_ISSUE. It is sampled only in S_SEG_INIT and S_STALL.
//  - Segments:
//    - Unit-stride: one segment at req_addr<<1, length nr_elem<<sew nibbles.
//    - Strided: nr_elem segments of 1<<sew nibbles. Segment k starts at (req_addr + k*stride)<<1, using a running adder.
//  - Txn size: nbs = min(seg_rmn, MaxTxnNbs - (cur_addr mod MaxTxnNbs)). On handshake: cur_addr += nbs, seg_rmn -= nbs.
//  - End of segment (seg_rmn==nbs):
//    - if segments remain -> next segment loads directly in the same handshake cycle, no bubble;
//    - else txn_last_o=1 and handshake -> S_IDLE with done_o pulsed that cycle.
//  - First/last flags: txn_first_o=1 only on the first descriptor after acceptance. First and last can be set together.
//  - Arithmetic:
//    - All address math wraps modulo 2^(AddrW+1); negative strides work via wrap.
//    - seg_rmn is ElemW+4 bits wide; no saturation.
//  - Throughput: one descriptor per cycle while txn_ready_i=1. Request-accept to first txn_valid_o takes 2 cycles when unstalled.
// CONFIGURATION
//  Macro VLSU_SPLIT_STRIDE_MERGE_EN:
//  - Defined: a strided request with (req_stride_i<<1)==(1<<req_sew_i) is decoded as unit-stride,
//    giving one contiguous segment and fewer txns.
//  - Undefined: strided requests are always handled per element.
// STRUCTURE
//  - riva_pkg: split_state_e enum; split_txn_t struct {addr, nbs, first, last, id}; function nbs_to_boundary().
//  - Sub-module vlsu_txn_size_calc (combinational): cur_addr, seg_rmn -> nbs and seg_end. Single instance, shared.
// TESTING
//  - Unit-stride addr=0x0FF0, nr_elem=64, sew=2 (256 nbs) -> 2 txns:
//    (0x1FE0, 32 nbs, first) and (0x2000, 224 nbs, last); done_o pulses on the 2nd handshake.
//  - Strided addr=0x100, stride=0x40, nr_elem=3, sew=3 -> nbs=8 at 0x200, 0x280, 0x300;
//    last only on the 3rd; with the macro defined and stride=4, sew=3 -> a single 24-nib txn.
//  - stall_i=1 for 5 cycles after acceptance -> txn_valid_o stays 0 through S_STALL.
//    First descriptor appears the cycle after stall_i falls.
//  - txn_ready_i low 3 cycles mid-burst -> descriptor fields unchanged; no txn lost or duplicated.
//  - nr_elem=0 -> no txn_valid_o; done_o pulses once; req_ready_o stays 1. Also: rst_ni asserted mid-ISSUE
//    -> outputs return to reset values.
//  - Negative stride -8 from addr 0x10, nr_elem=3, sew=3 -> txns at nibble 0x20, 0x10, 0x00.

Source files
------------

// File: rtl/vlsu_txn_splitter_pkg.sv
// ----------------------------------------------------------------------------
// vlsu_txn_splitter_pkg
//   Shared types and helpers for the VLSU transaction splitter.
//   - split_state_e   : splitter FSM states
//   - split_txn_t     : descriptor view {addr, nbs, first, last, id} at the
//                       default widths (AddrW=64, IdW=4, MaxTxnNbs=8192)
//   - nbs_to_boundary : nibbles left before the next MaxTxnNbs-aligned window
// Optional feature macro used by the splitter: VLSU_SPLIT_STRIDE_MERGE_EN
// ----------------------------------------------------------------------------
package vlsu_txn_splitter_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEG_INIT = 2'd1,
        S_STALL    = 2'd2,
        S_ISSUE    = 2'd3
    } split_state_e;

    localparam int unsigned DEF_ADDR_W      = 64;
    localparam int unsigned DEF_ID_W        = 4;
    localparam int unsigned DEF_MAX_TXN_NBS = 8192;
    localparam int unsigned DEF_NBS_W       = $clog2(DEF_MAX_TXN_NBS) + 1;

    typedef struct packed {
        logic [DEF_ADDR_W:0]   addr;
        logic [DEF_NBS_W-1:0]  nbs;
        logic                  first;
        logic                  last;
        logic [DEF_ID_W-1:0]   id;
    } split_txn_t;

    // max_nbs is a power of two, so the offset inside the window only needs
    // the low address bits; the result is always in 1..max_nbs.
    function automatic logic [31:0] nbs_to_boundary(input logic [31:0] addr_lo,
                                                    input logic [31:0] max_nbs);
        return max_nbs - (addr_lo & (max_nbs - 32'd1));
    endfunction

endpackage

// File: rtl/vlsu_txn_splitter_size_calc.sv
// ----------------------------------------------------------------------------
// vlsu_txn_size_calc (combinational)
//   Sizes the current descriptor: nbs = min(seg_rmn, room to next window).
//   Ports:
//     cur_addr  in   AddrW+1   nibble address of the current descriptor
//     seg_rmn   in   ElemW+4   nibbles remaining in the current segment
//     nbs       out  NbsW      descriptor size, 1..MaxTxnNbs
//     seg_end   out  1         descriptor finishes the segment
// ----------------------------------------------------------------------------
module vlsu_txn_size_calc
    import vlsu_txn_splitter_pkg::*;
#(
    parameter int unsigned AddrW     = 64,
    parameter int unsigned ElemW     = 16,
    parameter int unsigned MaxTxnNbs = 8192,
    localparam int unsigned RmnW     = ElemW + 4,
    localparam int unsigned NbsW     = $clog2(MaxTxnNbs) + 1
) (
    input  logic [AddrW:0]    cur_addr,
    input  logic [RmnW-1:0]   seg_rmn,
    output logic [NbsW-1:0]   nbs,
    output logic              seg_end
);

    logic [31:0] room;
    logic [31:0] rmn;

    always_comb begin
        room    = nbs_to_boundary(32'(cur_addr), 32'(MaxTxnNbs));
        rmn     = 32'(seg_rmn);
        seg_end = (rmn <= room);
        nbs     = seg_end ? NbsW'(rmn) : NbsW'(room);
    end

endmodule

// File: rtl/vlsu_txn_splitter.sv
// ----------------------------------------------------------------------------
// vlsu_txn_splitter
//   Turns one VLSU request (unit-stride or strided) into a stream of memory
//   transaction descriptors, none of which crosses a MaxTxnNbs-aligned window.
//   One request in flight; done_o pulses once per request.
//   Optional macro: VLSU_SPLIT_STRIDE_MERGE_EN -- a strided request whose
//   stride equals the element size is handled as one contiguous segment.
//
//   Handshakes: a transfer happens on a rising clk_i edge where valid and
//   ready are both 1. req_ready_o is 1 only in S_IDLE. Once txn_valid_o
//   rises it stays 1 with all txn_* fields constant until txn_ready_i=1.
//
//   Ports:
//     clk_i, rst_ni       clock, asynchronous active-low reset
//     req_*               request (valid/ready, addr, stride, nr_elem, sew,
//                         strd, id)
//     stall_i             downstream busy, sampled only before issuing a request
//     txn_*               descriptor stream (valid/ready, addr, nbs, first,
//                         last, id)
//     done_o              one-cycle pulse the cycle after the request completes
//     dbg_state           current FSM state
// ----------------------------------------------------------------------------
module vlsu_txn_splitter
    import vlsu_txn_splitter_pkg::*;
#(
    parameter int unsigned AddrW     = 64,
    parameter int unsigned ElemW     = 16,
    parameter int unsigned IdW       = 4,
    parameter int unsigned MaxTxnNbs = 8192,
    localparam int unsigned RmnW     = ElemW + 4,
    localparam int unsigned NbsW     = $clog2(MaxTxnNbs) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [AddrW-1:0]   req_addr_i,
    input  logic [AddrW-1:0]   req_stride_i,
    input  logic [ElemW-1:0]   req_nr_elem_i,
    input  logic [1:0]         req_sew_i,
    input  logic               req_strd_i,
    input  logic [IdW-1:0]     req_id_i,
    input  logic               stall_i,
    output logic               txn_valid_o,
    input  logic               txn_ready_i,
    output logic [AddrW:0]     txn_addr_o,
    output logic [NbsW-1:0]    txn_nbs_o,
    output logic               txn_first_o,
    output logic               txn_last_o,
    output logic [IdW-1:0]     txn_id_o,
    output logic               done_o,
    output split_state_e       dbg_state
);

    split_state_e      state;
    logic [AddrW:0]    next_seg_addr;  // start of the segment after the current one
    logic [AddrW:0]    stride_nbs;
    logic [AddrW:0]    cur_addr;
    logic [RmnW-1:0]   seg_len;
    logic [RmnW-1:0]   seg_rmn;
    logic [ElemW-1:0]  segs_left;      // segments still to load after the current one
    logic              first_q;
    logic              done_q;
    logic [IdW-1:0]    id_q;

    logic [NbsW-1:0]   nbs;
    logic              seg_end;

    logic [AddrW:0]    req_base;
    logic [AddrW:0]    req_stride_nbs;
    logic              unit_mode;

    always_comb begin
        req_base       = {req_addr_i, 1'b0};
        req_stride_nbs = {req_stride_i, 1'b0};
`ifdef VLSU_SPLIT_STRIDE_MERGE_EN
        // Stride equal to the element size is contiguous memory.
        unit_mode = !req_strd_i || (req_stride_nbs == ((AddrW+1)'(1) << req_sew_i));
`else
        unit_mode = !req_strd_i;
`endif
    end

    vlsu_txn_size_calc #(
        .AddrW     (AddrW),
        .ElemW     (ElemW),
        .MaxTxnNbs (MaxTxnNbs)
    ) u_size_calc (
        .cur_addr (cur_addr),
        .seg_rmn  (seg_rmn),
        .nbs      (nbs),
        .seg_end  (seg_end)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            next_seg_addr <= '0;
            stride_nbs    <= '0;
            cur_addr      <= '0;
            seg_len       <= '0;
            seg_rmn       <= '0;
            segs_left     <= '0;
            first_q       <= 1'b0;
            done_q        <= 1'b0;
            id_q          <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        id_q    <= req_id_i;
                        first_q <= 1'b1;
                        if (req_nr_elem_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            next_seg_addr <= req_base;
                            stride_nbs    <= req_stride_nbs;
                            if (unit_mode) begin
                                seg_len   <= RmnW'(req_nr_elem_i) << req_sew_i;
                                segs_left <= '0;
                            end else begin
                                seg_len   <= RmnW'(1) << req_sew_i;
                                segs_left <= req_nr_elem_i - ElemW'(1);
                            end
                            state <= S_SEG_INIT;
                        end
                    end
                end
                S_SEG_INIT: begin
                    cur_addr      <= next_seg_addr;
                    seg_rmn       <= seg_len;
                    next_seg_addr <= next_seg_addr + stride_nbs;
                    state         <= stall_i ? S_STALL : S_ISSUE;
                end
                S_STALL: begin
                    if (!stall_i) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (txn_ready_i) begin
                        first_q <= 1'b0;
                        if (!seg_end) begin
                            cur_addr <= cur_addr + (AddrW+1)'(nbs);
                            seg_rmn  <= seg_rmn - RmnW'(nbs);
                        end else if (segs_left != '0) begin
                            // Next strided element loads in the same cycle: no bubble.
                            cur_addr      <= next_seg_addr;
                            seg_rmn       <= seg_len;
                            next_seg_addr <= next_seg_addr + stride_nbs;
                            segs_left     <= segs_left - ElemW'(1);
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign txn_valid_o = (state == S_ISSUE);
    assign txn_addr_o  = cur_addr;
    assign txn_nbs_o   = nbs;
    assign txn_first_o = first_q;
    assign txn_last_o  = seg_end && (segs_left == '0);
    assign txn_id_o    = id_q;
    assign done_o      = done_q;
    assign dbg_state   = state;

endmodule
